// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: halts the 6502 via RDY and copies one 256-byte page to the OAM data port.
// While idle, the CPU bus passes straight through to memory.
module oam_dma_ctrl #(
    parameter logic [15:0] REG_ADDR = 16'h4014,
    parameter logic [15:0] DST_ADDR = 16'h2004
) (
    input  logic        CLK,
    input  logic        n_RES,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rnw,
    input  logic [7:0]  mem_din,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    output logic        bus_rnw,
    output logic        bus_owner,
    output logic        RDY,
    output logic        dma_busy,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic        par_q, par_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            state_q <= IDLE;
            par_q   <= 1'b0;
            idx_q   <= 8'h00;
            page_q  <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        par_d   = ~par_q;
        idx_d   = idx_q;
        page_d  = page_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!cpu_rnw && cpu_a == REG_ADDR) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            HALT: begin
                // The core only honours RDY on a read; par=1 now means the next cycle is a get.
                if (cpu_rnw) begin
                    state_d = par_q ? READ : ALIGN;
                end
            end
            ALIGN: state_d = READ;
            READ: begin
                data_d  = mem_din;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d = idx_q + 8'h01;
                if (idx_q == 8'hFF) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign RDY       = (state_q == IDLE);
    assign bus_owner = (state_q == READ) || (state_q == WRITE);
    assign dma_busy  = (state_q != IDLE);
    assign dma_done  = done_q;

    always_comb begin
        bus_a    = cpu_a;
        bus_dout = cpu_dout;
        bus_rnw  = cpu_rnw;
        if (state_q == READ) begin
            bus_a    = {page_q, idx_q};
            bus_dout = data_q;
            bus_rnw  = 1'b1;
        end else if (state_q == WRITE) begin
            bus_a    = DST_ADDR;
            bus_dout = data_q;
            bus_rnw  = 1'b0;
        end
    end

endmodule
